// File: rtl/out_packet_arbiter_if.sv
// Packet-source / Sender handshake bundle for out_packet_arbiter.
// master: the arbiter side; slave: sources and Sender.
interface out_packet_arbiter_if;
  logic        pwr_req;
  logic        kb_req;
  logic [39:0] kb_data;
  logic        kb_done;
  logic        mic_req;
  logic [39:0] mic_data;
  logic        mic_done;
  logic [39:0] out_data;
  logic        out_valid;
  logic        out_retrieved;
  logic        drop_pulse;

  modport master (
    input  pwr_req, kb_req, kb_data, mic_req, mic_data, out_retrieved,
    output kb_done, mic_done, out_data, out_valid, drop_pulse
  );

  modport slave (
    output pwr_req, kb_req, kb_data, mic_req, mic_data, out_retrieved,
    input  kb_done, mic_done, out_data, out_valid, drop_pulse
  );
endinterface

// File: rtl/out_packet_arbiter.sv
// Shares the monitor-link Sender among power-on, keyboard/mouse and mic packet sources.
// Optional ARB_STATS_EN adds saturating sent/drop counters.
module out_packet_arbiter #(
  parameter logic [39:0] POWER_ON_PKT = 40'hC0_0000_0000,
  parameter int unsigned GAP          = 2,
  parameter int unsigned ACK_TIMEOUT  = 16384,
  parameter int unsigned MAX_RETRY    = 3
) (
  input  logic                 mon_clk,
  input  logic                 hw_reset_n,
  out_packet_arbiter_if.master bus_io
`ifdef ARB_STATS_EN
  ,
  output logic [15:0]          stat_kb_sent,
  output logic [15:0]          stat_mic_sent,
  output logic [7:0]           stat_drops
`endif
);

  typedef enum logic [1:0] {StIdle, StLoad, StOffer, StGap} state_e;
  typedef enum logic [1:0] {SrcPwr, SrcKb, SrcMic} src_e;

  localparam logic [15:0] TimerLast = 16'(ACK_TIMEOUT - 1);
  localparam logic [2:0]  RetryMax  = 3'(MAX_RETRY);
  localparam logic [3:0]  GapLast   = 4'(GAP - 1);

  state_e      state_q;
  src_e        owner_q;
  src_e        rr_last_q;
  logic [39:0] out_data_q;
  logic        out_valid_q;
  logic        kb_done_q;
  logic        mic_done_q;
  logic        drop_q;
  logic        pwr_pend_q;
  logic        retry_pend_q;
  logic [15:0] timer_q;
  logic [2:0]  retry_q;
  logic [3:0]  gap_cnt_q;

  logic grant_valid;
  src_e grant_src;
  logic offer_ok;
  logic offer_drop;
  logic consume;

  always_comb begin
    grant_valid = 1'b1;
    grant_src   = SrcPwr;
    if (pwr_pend_q) begin
      grant_src = SrcPwr;
    end else if (bus_io.kb_req && bus_io.mic_req) begin
      grant_src = (rr_last_q == SrcMic) ? SrcKb : SrcMic;
    end else if (bus_io.kb_req) begin
      grant_src = SrcKb;
    end else if (bus_io.mic_req) begin
      grant_src = SrcMic;
    end else begin
      grant_valid = 1'b0;
    end
  end

  // A retrieve in the timeout cycle still counts as success.
  assign offer_ok   = (state_q == StOffer) && bus_io.out_retrieved;
  assign offer_drop = (state_q == StOffer) && !bus_io.out_retrieved &&
                      (timer_q == TimerLast) && (retry_q == RetryMax);
  assign consume    = offer_ok || offer_drop;

  always_ff @(posedge mon_clk or negedge hw_reset_n) begin
    if (!hw_reset_n) begin
      state_q      <= StIdle;
      owner_q      <= SrcPwr;
      rr_last_q    <= SrcMic;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      kb_done_q    <= 1'b0;
      mic_done_q   <= 1'b0;
      drop_q       <= 1'b0;
      pwr_pend_q   <= 1'b0;
      retry_pend_q <= 1'b0;
      timer_q      <= '0;
      retry_q      <= '0;
      gap_cnt_q    <= '0;
    end else begin
      kb_done_q  <= 1'b0;
      mic_done_q <= 1'b0;
      drop_q     <= 1'b0;

      if (consume) begin
        kb_done_q  <= (owner_q == SrcKb);
        mic_done_q <= (owner_q == SrcMic);
        if (owner_q != SrcPwr) rr_last_q <= owner_q;
        if (owner_q == SrcPwr) pwr_pend_q <= 1'b0;
      end
      // A fresh pulse on the consume edge is a new request and wins over the clear.
      if (bus_io.pwr_req) pwr_pend_q <= 1'b1;

      unique case (state_q)
        StIdle: begin
          if (grant_valid) begin
            owner_q <= grant_src;
            state_q <= StLoad;
          end
        end
        StLoad: begin
          // Retries re-offer the latched copy; the source may have moved on.
          if (!retry_pend_q) begin
            case (owner_q)
              SrcKb:   out_data_q <= bus_io.kb_data;
              SrcMic:  out_data_q <= bus_io.mic_data;
              default: out_data_q <= POWER_ON_PKT;
            endcase
          end
          out_valid_q  <= 1'b1;
          timer_q      <= '0;
          retry_pend_q <= 1'b0;
          state_q      <= StOffer;
        end
        StOffer: begin
          gap_cnt_q <= '0;
          if (bus_io.out_retrieved) begin
            out_valid_q <= 1'b0;
            retry_q     <= '0;
            state_q     <= StGap;
          end else if (timer_q == TimerLast) begin
            out_valid_q <= 1'b0;
            state_q     <= StGap;
            if (retry_q == RetryMax) begin
              drop_q  <= 1'b1;
              retry_q <= '0;
            end else begin
              retry_q      <= retry_q + 3'd1;
              retry_pend_q <= 1'b1;
            end
          end else begin
            timer_q <= timer_q + 16'd1;
          end
        end
        StGap: begin
          if (gap_cnt_q == GapLast) begin
            state_q <= retry_pend_q ? StLoad : StIdle;
          end else begin
            gap_cnt_q <= gap_cnt_q + 4'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus_io.out_data   = out_data_q;
  assign bus_io.out_valid  = out_valid_q;
  assign bus_io.kb_done    = kb_done_q;
  assign bus_io.mic_done   = mic_done_q;
  assign bus_io.drop_pulse = drop_q;

`ifdef ARB_STATS_EN
  logic [15:0] stat_kb_q;
  logic [15:0] stat_mic_q;
  logic [7:0]  stat_drop_q;

  always_ff @(posedge mon_clk or negedge hw_reset_n) begin
    if (!hw_reset_n) begin
      stat_kb_q   <= '0;
      stat_mic_q  <= '0;
      stat_drop_q <= '0;
    end else begin
      if (offer_ok && (owner_q == SrcKb) && (stat_kb_q != '1)) stat_kb_q <= stat_kb_q + 16'd1;
      if (offer_ok && (owner_q == SrcMic) && (stat_mic_q != '1)) begin
        stat_mic_q <= stat_mic_q + 16'd1;
      end
      if (offer_drop && (stat_drop_q != '1)) stat_drop_q <= stat_drop_q + 8'd1;
    end
  end

  assign stat_kb_sent  = stat_kb_q;
  assign stat_mic_sent = stat_mic_q;
  assign stat_drops    = stat_drop_q;
`endif

endmodule

// File: tb/tb_out_packet_arbiter.sv
// Randomized bench for out_packet_arbiter against a transaction-level arbitration model.
module tb_out_packet_arbiter;
  localparam int unsigned AckTo     = 8;
  localparam int unsigned MaxRetry  = 3;
  localparam int unsigned GapCycles = 2;
  localparam logic [39:0] PwrPkt    = 40'hC0_0000_0000;
  localparam int SrcPwr = 0;
  localparam int SrcKb  = 1;
  localparam int SrcMic = 2;

  logic mon_clk    = 1'b0;
  logic hw_reset_n = 1'b0;
  out_packet_arbiter_if bus ();
`ifdef ARB_STATS_EN
  logic [15:0] stat_kb_sent;
  logic [15:0] stat_mic_sent;
  logic [7:0]  stat_drops;
`endif

  out_packet_arbiter #(
    .POWER_ON_PKT(PwrPkt),
    .GAP         (GapCycles),
    .ACK_TIMEOUT (AckTo),
    .MAX_RETRY   (MaxRetry)
  ) dut (
    .mon_clk   (mon_clk),
    .hw_reset_n(hw_reset_n),
    .bus_io    (bus)
`ifdef ARB_STATS_EN
    ,
    .stat_kb_sent (stat_kb_sent),
    .stat_mic_sent(stat_mic_sent),
    .stat_drops   (stat_drops)
`endif
  );

  always #5 mon_clk = ~mon_clk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int rr_last_m  = SrcMic;
  int force_mode = 0;  // 0 random, 1 fixed delay, 2 never, 3 first attempt times out
  int force_d    = 0;
  int exp_kb_sent = 0;
  int exp_mic_sent = 0;
  int exp_drops = 0;

  task automatic check_eq(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Sender behaviour per attempt: retrieve after d cycles of valid, or -1 for never.
  function automatic int pick_delay(input int attempt);
    if (force_mode == 1) return force_d;
    if (force_mode == 2) return -1;
    if (force_mode == 3) return (attempt == 0) ? -1 : int'(AckTo) - 1;
    if ($urandom_range(0, 3) == 0) return -1;
    return int'($urandom_range(0, AckTo - 1));
  endfunction

  function automatic logic [39:0] pulses(input int src, input bit drop);
    return 40'({src == SrcKb, src == SrcMic, drop});
  endfunction

  task automatic run_offer(input int src, input logic [39:0] pkt, input bit inject,
                           output bit injected);
    int d;
    int budget;
    int len;
    bit consumed;
    injected = 1'b0;
    consumed = 1'b0;
    for (int a = 0; a <= int'(MaxRetry) && !consumed; a++) begin
      budget = 0;
      while (!bus.out_valid && budget < 40) begin
        @(negedge mon_clk);
        budget++;
      end
      if (!bus.out_valid) begin
        check_eq("valid_wait", 40'(bus.out_valid), 40'd1);
        return;
      end
      check_eq("offer_data", bus.out_data, pkt);
      if (inject && a == 0) begin
        injected    = 1'b1;
        bus.pwr_req = 1'b1;
        fork
          begin
            @(negedge mon_clk);
            bus.pwr_req = 1'b0;
          end
        join_none
      end
      d = pick_delay(a);
      if (d >= 0) begin
        repeat (d) @(negedge mon_clk);
        bus.out_retrieved = 1'b1;
        @(negedge mon_clk);
        bus.out_retrieved = 1'b0;
        check_eq("ok_valid_low", 40'(bus.out_valid), 40'd0);
        check_eq("ok_pulses", 40'({bus.kb_done, bus.mic_done, bus.drop_pulse}), pulses(src, 1'b0));
        if (src == SrcKb) exp_kb_sent++;
        if (src == SrcMic) exp_mic_sent++;
        consumed = 1'b1;
      end else begin
        len = 0;
        while (bus.out_valid && len < int'(AckTo) + 4) begin
          len++;
          @(negedge mon_clk);
        end
        check_eq("offer_len", 40'(len), 40'(AckTo));
        if (a == int'(MaxRetry)) begin
          check_eq("drop_pulses", 40'({bus.kb_done, bus.mic_done, bus.drop_pulse}),
                   pulses(src, 1'b1));
          exp_drops++;
          consumed = 1'b1;
        end else begin
          check_eq("retry_quiet", 40'({bus.kb_done, bus.mic_done, bus.drop_pulse}), 40'd0);
        end
      end
    end
    if (src == SrcKb) bus.kb_req = 1'b0;
    if (src == SrcMic) bus.mic_req = 1'b0;
    // Stray retrieve while nothing is offered must be ignored.
    if ($urandom_range(0, 1) == 1) begin
      bus.out_retrieved = 1'b1;
      @(negedge mon_clk);
      bus.out_retrieved = 1'b0;
    end
  endtask

  task automatic run_round(input bit do_pwr, input bit do_kb, input bit do_mic,
                           input bit inject_ok, input logic [39:0] kd_fix);
    bit p_pwr, p_kb, p_mic, injected, inj_used;
    int src;
    logic [39:0] pkt, kd, md;
    logic [63:0] r;
    r  = {$urandom, $urandom};
    kd = (kd_fix != '0) ? kd_fix : r[39:0];
    r  = {$urandom, $urandom};
    md = r[39:0];
    if (do_pwr) begin
      bus.pwr_req = 1'b1;
      @(negedge mon_clk);
      bus.pwr_req = 1'b0;
    end
    if (do_kb) begin
      bus.kb_data = kd;
      bus.kb_req  = 1'b1;
    end
    if (do_mic) begin
      bus.mic_data = md;
      bus.mic_req  = 1'b1;
    end
    p_pwr    = do_pwr;
    p_kb     = do_kb;
    p_mic    = do_mic;
    inj_used = !inject_ok;
    while (p_pwr || p_kb || p_mic) begin
      if (p_pwr) src = SrcPwr;
      else if (p_kb && p_mic) src = (rr_last_m == SrcKb) ? SrcMic : SrcKb;
      else if (p_kb) src = SrcKb;
      else src = SrcMic;
      pkt = (src == SrcPwr) ? PwrPkt : (src == SrcKb) ? kd : md;
      run_offer(src, pkt, !inj_used && src != SrcPwr, injected);
      if (injected) begin
        p_pwr    = 1'b1;
        inj_used = 1'b1;
      end
      if (src == SrcPwr) p_pwr = 1'b0;
      else rr_last_m = src;
      if (src == SrcKb) p_kb = 1'b0;
      if (src == SrcMic) p_mic = 1'b0;
    end
    repeat (8) @(negedge mon_clk);
    check_eq("idle_quiet", 40'({bus.out_valid, bus.kb_done, bus.mic_done, bus.drop_pulse}), 40'd0);
  endtask

  initial begin
    int budget;
    bus.pwr_req       = 1'b0;
    bus.kb_req        = 1'b0;
    bus.kb_data       = '0;
    bus.mic_req       = 1'b0;
    bus.mic_data      = '0;
    bus.out_retrieved = 1'b0;
    #1;
    check_eq("rst_valid", 40'(bus.out_valid), 40'd0);
    check_eq("rst_data", bus.out_data, 40'd0);
    check_eq("rst_pulses", 40'({bus.kb_done, bus.mic_done, bus.drop_pulse}), 40'd0);
    repeat (2) @(negedge mon_clk);
    hw_reset_n = 1'b1;
    @(negedge mon_clk);

    force_mode = 1; force_d = 3;
    run_round(1'b0, 1'b1, 1'b0, 1'b0, 40'h12_3456_789A);
    force_mode = 0;
    run_round(1'b0, 1'b1, 1'b1, 1'b0, '0);
    force_mode = 2;
    run_round(1'b0, 1'b0, 1'b1, 1'b0, '0);
    force_mode = 1; force_d = int'(AckTo) - 1;
    run_round(1'b0, 1'b1, 1'b0, 1'b0, '0);
    force_mode = 3;
    run_round(1'b0, 1'b1, 1'b0, 1'b0, '0);
    force_mode = 2;
    run_round(1'b0, 1'b1, 1'b0, 1'b0, '0);
    force_mode = 0;
    run_round(1'b0, 1'b1, 1'b1, 1'b1, '0);
    run_round(1'b1, 1'b1, 1'b1, 1'b0, '0);
    for (int i = 0; i < 30; i++) begin
      run_round(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), '0);
    end

    // Reset in the middle of an offer.
    bus.kb_data = 40'hAB_CDEF_0123;
    bus.kb_req  = 1'b1;
    budget = 0;
    while (!bus.out_valid && budget < 40) begin
      @(negedge mon_clk);
      budget++;
    end
    check_eq("pre_rst_offer", 40'(bus.out_valid), 40'd1);
    hw_reset_n = 1'b0;
    #1;
    check_eq("mid_rst_valid", 40'(bus.out_valid), 40'd0);
    check_eq("mid_rst_data", bus.out_data, 40'd0);
    bus.kb_req = 1'b0;
    @(negedge mon_clk);
    hw_reset_n   = 1'b1;
    rr_last_m    = SrcMic;
    exp_kb_sent  = 0;
    exp_mic_sent = 0;
    exp_drops    = 0;
    repeat (6) begin
      @(negedge mon_clk);
      check_eq("post_rst_quiet",
               40'({bus.out_valid, bus.kb_done, bus.mic_done, bus.drop_pulse}), 40'd0);
    end
    run_round(1'b0, 1'b1, 1'b1, 1'b0, '0);

`ifdef ARB_STATS_EN
    check_eq("stat_kb", 40'(stat_kb_sent), 40'(exp_kb_sent));
    check_eq("stat_mic", 40'(stat_mic_sent), 40'(exp_mic_sent));
    check_eq("stat_drops", 40'(stat_drops), 40'(exp_drops));
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
